// File: rtl/calc_sched_16_pkg.sv
// calc_defs: shared opcodes, FSM state encodings, widths and payload types
// for the two-requester calculator scheduler and its int_calc_16 engine.
package calc_defs;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned OP_W         = 3;
    localparam int unsigned ST_W         = 2;
    localparam int unsigned CALC_LAT_DEF = 1;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
    localparam logic [OP_W-1:0] OP_EXP   = 3'd4;
    localparam logic [OP_W-1:0] OP_LOG10 = 3'd5;
    localparam logic [OP_W-1:0] OP_POW   = 3'd6;
    localparam logic [OP_W-1:0] OP_MOD   = 3'd7;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

    // Latched request payload.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } calc_req_t;

    // Held result payload.
    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              sign;
        logic              err;
    } calc_res_t;

    // Division or modulo by zero never reaches the engine.
    function automatic logic is_div_zero(input calc_req_t r);
        return ((r.op == OP_DIV) || (r.op == OP_MOD)) && (r.b == '0);
    endfunction

endpackage

// File: rtl/int_calc_16.sv
// int_calc_16: 16-bit integer calculator with a fixed CALC_LAT-cycle latency
// from an en pulse to valid sum/sign.
// Ports: clk; reset (async, active-high); en, op, a, b in; sum, sign out.
module int_calc_16
    import calc_defs::*;
#(
    parameter int unsigned CALC_LAT = CALC_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              sign
);

    localparam int unsigned DEPTH = (CALC_LAT < 1) ? 1 : CALC_LAT;

    // Square-and-multiply over the low four exponent bits.
    function automatic logic [DATA_W-1:0] pow16(input logic [DATA_W-1:0] base_i,
                                                input logic [3:0]        e);
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] base;
        res  = DATA_W'(1);
        base = base_i;
        for (int i = 0; i < 4; i++) begin
            if (e[i]) res = DATA_W'(res * base);
            base = DATA_W'(base * base);
        end
        return res;
    endfunction

    logic [DATA_W-1:0]   r_sum;
    logic                r_sign;
    logic [2*DATA_W-1:0] prod;

    // Combinational result of the current operands.
    always_comb begin
        r_sum  = '0;
        r_sign = 1'b0;
        prod   = a * b;
        case (op)
            OP_ADD:   r_sum = DATA_W'(a + b);
            OP_SUB: begin
                r_sum  = DATA_W'(a - b);
                r_sign = (a < b);
            end
            OP_MUL:   r_sum = prod[DATA_W-1:0];
            OP_DIV:   r_sum = (b == '0) ? '1 : DATA_W'(a / b);
            OP_EXP:   r_sum = DATA_W'(1) << a[3:0];
            OP_LOG10: begin
                if      (a >= DATA_W'(10000)) r_sum = DATA_W'(4);
                else if (a >= DATA_W'(1000))  r_sum = DATA_W'(3);
                else if (a >= DATA_W'(100))   r_sum = DATA_W'(2);
                else if (a >= DATA_W'(10))    r_sum = DATA_W'(1);
                else                          r_sum = '0;
            end
            OP_POW:   r_sum = pow16(a, b[3:0]);
            OP_MOD:   r_sum = (b == '0) ? '1 : DATA_W'(a % b);
            default:  r_sum = '0;
        endcase
    end

    logic [DATA_W-1:0] sum_pipe  [DEPTH];
    logic              sign_pipe [DEPTH];

    // Stage 0 loads on en; later stages just delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sum_pipe[i]  <= '0;
                sign_pipe[i] <= 1'b0;
            end
        end else begin
            if (en) begin
                sum_pipe[0]  <= r_sum;
                sign_pipe[0] <= r_sign;
            end
            for (int i = 1; i < DEPTH; i++) begin
                sum_pipe[i]  <= sum_pipe[i-1];
                sign_pipe[i] <= sign_pipe[i-1];
            end
        end
    end

    assign sum  = sum_pipe[DEPTH-1];
    assign sign = sign_pipe[DEPTH-1];

endmodule

// File: rtl/calc_sched_16.sv
// calc_sched_16: round-robin scheduler sharing one int_calc_16 between two
// requesters, with valid/ready request and response handshakes.
// Ports: clk, rst (async active-low); reqN_valid/op/a/b in, reqN_ready out;
// respN_valid/sum/sign/err out, respN_ready in; busy out (state != IDLE).
module calc_sched_16
    import calc_defs::*;
#(
    parameter int unsigned CALC_LAT = CALC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_sum,
    output logic              resp0_sign,
    output logic              resp0_err,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_sum,
    output logic              resp1_sign,
    output logic              resp1_err,
    output logic              busy
);

    // Extra bit keeps the end-of-wait compare meaningful for CALC_LAT=1.
    localparam int unsigned CW = $clog2(CALC_LAT + 2) + 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic              last_grant_q;
    logic              grant_q;
    calc_req_t         req_q;
    logic [CW-1:0]     cnt_q;
    calc_res_t         res_q;

    logic              gnt_any, gnt_idx;
    calc_req_t         req_sel;
    logic              resp_ready_sel;
    logic              accept, dz, load_cnt, dec_cnt, capture;
    logic              calc_en;
    logic [DATA_W-1:0] calc_sum;
    logic              calc_sign;

    // Round-robin: on contention the requester not granted last time wins.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) gnt_idx = ~last_grant_q;
        else                          gnt_idx = req1_valid;
        req_sel        = gnt_idx ? '{op: req1_op, a: req1_a, b: req1_b}
                                 : '{op: req0_op, a: req0_a, b: req0_b};
        resp_ready_sel = grant_q ? resp1_ready : resp0_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        dz       = 1'b0;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    accept = 1'b1;
                    if (is_div_zero(req_sel)) begin
                        dz      = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                load_cnt = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                dec_cnt = 1'b1;
                // Counter reaching zero on this edge: engine output is valid now.
                if (cnt_q < CW'(2)) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_sel) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, grant history, wait counter and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            req_q        <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
        end else begin
            if (accept) begin
                req_q        <= req_sel;
                grant_q      <= gnt_idx;
                last_grant_q <= gnt_idx;
            end
            if (load_cnt)                     cnt_q <= CW'(CALC_LAT);
            else if (dec_cnt && cnt_q != '0)  cnt_q <= cnt_q - CW'(1);
            if (dz)      res_q <= '{sum: {DATA_W{1'b1}}, sign: 1'b0, err: 1'b1};
            if (capture) res_q <= '{sum: calc_sum, sign: calc_sign, err: 1'b0};
        end
    end

    assign calc_en = (state_q == ST_ISSUE);

    int_calc_16 #(.CALC_LAT(CALC_LAT)) u_calc (
        .clk   (clk),
        .reset (~rst),
        .en    (calc_en),
        .op    (req_q.op),
        .a     (req_q.a),
        .b     (req_q.b),
        .sum   (calc_sum),
        .sign  (calc_sign)
    );

    // Ready is gated by rst so nothing is offered while reset is held.
    assign req0_ready  = rst && (state_q == ST_IDLE) && gnt_any && !gnt_idx;
    assign req1_ready  = rst && (state_q == ST_IDLE) && gnt_any &&  gnt_idx;
    assign busy        = (state_q != ST_IDLE);

    assign resp0_valid = (state_q == ST_RESP) && !grant_q;
    assign resp1_valid = (state_q == ST_RESP) &&  grant_q;
    assign resp0_sum   = resp0_valid ? res_q.sum  : '0;
    assign resp0_sign  = resp0_valid && res_q.sign;
    assign resp0_err   = resp0_valid && res_q.err;
    assign resp1_sum   = resp1_valid ? res_q.sum  : '0;
    assign resp1_sign  = resp1_valid && res_q.sign;
    assign resp1_err   = resp1_valid && res_q.err;

endmodule

// File: tb/tb_calc_sched_16.sv
// Directed testbench for calc_sched_16 (CALC_LAT=1).
module tb_calc_sched_16;
    import calc_defs::*;

    localparam int unsigned LAT = 1;
    localparam int          TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [15:0] resp0_sum, resp1_sum;
    logic        resp0_sign, resp1_sign, resp0_err, resp1_err, busy;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;

    calc_sched_16 #(.CALC_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(resp0_sum),
        .resp0_sign(resp0_sign), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(resp1_sum),
        .resp1_sign(resp1_sign), .resp1_err(resp1_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine-enable pulses, observed at each rising edge.
    always @(posedge clk) if (dut.calc_en) en_cnt++;

    typedef struct {
        int          n;
        logic [2:0]  op;
        logic [15:0] a, b, sum;
        logic        sign, err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic rd_ready(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic rd_rvalid(input int n);
        return (n == 0) ? resp0_valid : resp1_valid;
    endfunction
    function automatic logic [17:0] rd_res(input int n);
        return (n == 0) ? {resp0_sum, resp0_sign, resp0_err} : {resp1_sum, resp1_sign, resp1_err};
    endfunction
    function automatic logic [39:0] all_outs();
        return {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_sum, resp1_sum,
                resp0_sign, resp1_sign, resp0_err, resp1_err, busy};
    endfunction

    task automatic set_req(input int n, input logic v, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    task automatic set_rready(input int n, input logic v);
        if (n == 0) resp0_ready = v; else resp1_ready = v;
    endtask

    // Wait (bounded) until requester n sees ready; called 1ns after a negedge.
    task automatic wait_ready(input int n, input string nm);
        int k = 0;
        while (!rd_ready(n) && k < TMO) begin @(negedge clk); #1; k++; end
        chk({nm, "_grant_tmo"}, 32'(k < TMO), 32'd1);
    endtask

    // Wait (bounded) for respN_valid; returns cycles counted from the accept cycle.
    task automatic wait_resp(input int n, input string nm, output int lat);
        lat = 1;
        while (!rd_rvalid(n) && lat < TMO) begin @(negedge clk); #1; lat++; end
        chk({nm, "_resp_tmo"}, 32'(lat < TMO), 32'd1);
    endtask

    task automatic consume(input int n, input string nm);
        set_rready(n, 1'b1);
        @(negedge clk); #1;
        set_rready(n, 1'b0);
        chk({nm, "_rvalid_after"}, 32'(rd_rvalid(n)), 32'd0);
    endtask

    // One complete lone-requester transaction with full result checking.
    task automatic run_op(input int n, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] es, input logic esg,
                          input logic eer, input string nm);
        int lat;
        int en0;
        en0 = en_cnt;
        @(negedge clk);
        set_req(n, 1'b1, op, a, b);
        #1;
        wait_ready(n, nm);
        @(negedge clk);
        set_req(n, 1'b0, 3'd0, 16'd0, 16'd0);
        #1;
        chk({nm, "_ready_pulse"}, 32'(rd_ready(n)), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        wait_resp(n, nm, lat);
        chk({nm, "_latency"}, 32'(lat), eer ? 32'd1 : 32'(LAT + 2));
        chk({nm, "_result"}, 32'(rd_res(n)), 32'({es, esg, eer}));
        chk({nm, "_other_rvalid"}, 32'(rd_rvalid(1 - n)), 32'd0);
        chk({nm, "_calc_en"}, 32'(en_cnt - en0), eer ? 32'd0 : 32'd1);
        consume(n, nm);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{0, OP_ADD,   16'd25,    16'd30,  16'd55,     1'b0, 1'b0};
        vecs[1]  = '{0, OP_SUB,   16'd25,    16'd30,  16'hFFFB,   1'b1, 1'b0};
        vecs[2]  = '{1, OP_MUL,   16'd300,   16'd300, 16'h5F90,   1'b0, 1'b0};
        vecs[3]  = '{1, OP_DIV,   16'd100,   16'd7,   16'd14,     1'b0, 1'b0};
        vecs[4]  = '{0, OP_MOD,   16'd100,   16'd7,   16'd2,      1'b0, 1'b0};
        vecs[5]  = '{1, OP_DIV,   16'd10,    16'd0,   16'hFFFF,   1'b0, 1'b1};
        vecs[6]  = '{0, OP_MOD,   16'd5,     16'd0,   16'hFFFF,   1'b0, 1'b1};
        vecs[7]  = '{0, OP_EXP,   16'd5,     16'd0,   16'd32,     1'b0, 1'b0};
        vecs[8]  = '{1, OP_LOG10, 16'd12345, 16'd0,   16'd4,      1'b0, 1'b0};
        vecs[9]  = '{1, OP_LOG10, 16'd0,     16'd0,   16'd0,      1'b0, 1'b0};
        vecs[10] = '{0, OP_POW,   16'd3,     16'd4,   16'd81,     1'b0, 1'b0};
        vecs[11] = '{1, OP_ADD,   16'hFFFF,  16'd1,   16'd0,      1'b0, 1'b0};

        // Reset: outputs quiet even with a requester valid.
        rst = 1'b0;
        set_req(0, 1'b1, OP_ADD, 16'd1, 16'd1);
        set_req(1, 1'b0, 3'd0, 16'd0, 16'd0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 32'(all_outs() != '0), 32'd0);
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_outs", 32'(all_outs() != '0), 32'd0);

        // Table of lone-requester operations.
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].n, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].sum, vecs[i].sign, vecs[i].err, $sformatf("vec%0d", i));

        // Contention: req0 first; req0 re-raised while req1 still waits -> req1 next.
        @(negedge clk);
        set_req(0, 1'b1, OP_SUB, 16'd20, 16'd5);
        set_req(1, 1'b1, OP_MUL, 16'd4, 16'd5);
        #1;
        chk("rr1_req0_ready", 32'(req0_ready), 32'd1);
        chk("rr1_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
        #1;
        wait_resp(0, "rr1", lat);
        chk("rr1_sum", 32'(resp0_sum), 32'd15);
        consume(0, "rr1");
        set_req(0, 1'b1, OP_SUB, 16'd20, 16'd5);
        #1;
        chk("rr2_req1_ready", 32'(req1_ready), 32'd1);
        chk("rr2_req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 16'd0, 16'd0);
        #1;
        wait_resp(1, "rr2", lat);
        chk("rr2_sum", 32'(resp1_sum), 32'd20);
        consume(1, "rr2");
        chk("rr3_req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
        #1;
        wait_resp(0, "rr3", lat);
        chk("rr3_sum", 32'(resp0_sum), 32'd15);
        consume(0, "rr3");

        // Backpressure on resp0 while req1 waits.
        @(negedge clk);
        set_req(0, 1'b1, OP_ADD, 16'd7, 16'd8);
        #1;
        wait_ready(0, "bp");
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
        set_req(1, 1'b1, OP_ADD, 16'd1, 16'd1);
        #1;
        wait_resp(0, "bp", lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("bp_rvalid", 32'(resp0_valid), 32'd1);
            chk("bp_sum", 32'(resp0_sum), 32'd15);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        consume(0, "bp");
        chk("bp_req1_granted", 32'(req1_ready), 32'd1);
        chk("bp_idle", 32'(busy), 32'd0);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 16'd0, 16'd0);
        #1;
        wait_resp(1, "bp1", lat);
        chk("bp1_sum", 32'(resp1_sum), 32'd2);
        consume(1, "bp1");

        // Reset during WAIT discards the operation.
        @(negedge clk);
        set_req(0, 1'b1, OP_SUB, 16'd25, 16'd30);
        #1;
        wait_ready(0, "rm");
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0);
        @(negedge clk); #1;
        chk("rm_in_wait", 32'(dut.state_q), 32'(ST_WAIT));
        set_req(1, 1'b1, OP_ADD, 16'd3, 16'd3);
        rst = 1'b0;
        #1;
        chk("rm_outs_now", 32'(all_outs() != '0), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rm_outs_held", 32'(all_outs() != '0), 32'd0);
        set_req(1, 1'b0, 3'd0, 16'd0, 16'd0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("rm_no_stale", 32'({resp0_valid, resp1_valid, busy}), 32'd0);
        end
        run_op(0, OP_ADD, 16'd10, 16'd2, 16'd12, 1'b0, 1'b0, "rm_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sched_16.md
CALC_SCHED_16 -- requirements
Module: calc_sched_16

Interface
REQ-001 SHALL have parameter CALC_LAT, default 1: cycles from the calc enable pulse to a valid sum/sign from int_calc_16.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port reqN_valid (N=0,1), input, 1: requester N presents an operation.
REQ-005 SHALL have port reqN_ready, output, 1: the operation is accepted this cycle when reqN_valid && reqN_ready.
REQ-006 SHALL have port reqN_op, input, 3: opcode 0..7 (add, sub, mul, div, exp, log10, pow, mod).
REQ-007 SHALL have ports reqN_a and reqN_b, input, 16: operands.
REQ-008 SHALL have port respN_valid, output, 1: the result for requester N is held.
REQ-009 SHALL have port respN_ready, input, 1: requester N consumes the result.
REQ-010 SHALL have ports respN_sum (output, 16) and respN_sign (output, 1): the result.
REQ-011 SHALL have port respN_err, output, 1: div/mod by zero.
REQ-012 SHALL have port busy, output, 1: high when the state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, ISSUE, WAIT, RESP; the state SHALL be IDLE after reset.
REQ-014 In IDLE, the block SHALL grant one valid requester by round-robin: a lone valid requester is always granted; when both are valid, the requester not granted last time wins.
REQ-015 reqN_ready SHALL be combinational, high only in IDLE for the granted requester, and low in all other states.
REQ-016 On handshake, the block SHALL latch op, a, b and the grant index, update last_grant, and go to ISSUE.
REQ-017 Requesters SHALL hold valid, op, a and b stable until ready; the block does not check this.
REQ-018 ISSUE SHALL last exactly one cycle.
REQ-019 In ISSUE, the block SHALL drive calc enable=1 with the latched op/a/b, load a counter with CALC_LAT, and go to WAIT.
REQ-020 Calc enable SHALL be 0 in every state except ISSUE.
REQ-021 WAIT SHALL decrement the counter each cycle; at count 0 it SHALL capture sum and sign into the result register and go to RESP.
REQ-022 Div by zero (op 3 or 7 with b=0) SHALL skip ISSUE and WAIT and go from IDLE directly to RESP with sum=16'hFFFF, sign=0, err=1.
REQ-023 In RESP, only the granted requester's respN_valid SHALL be 1; its sum, sign and err SHALL hold stable until respN_ready.
REQ-024 When respN_ready is high in RESP, the block SHALL go to IDLE; the next grant can happen in the following cycle.
REQ-025 While respN_ready stays low, the block SHALL stay in RESP indefinitely and accept no new requests.
REQ-026 The non-granted requester's respN_valid SHALL be 0 throughout.
REQ-027 respN_sum, respN_sign and respN_err SHALL read as 0 when respN_valid is 0.
REQ-028 Latency from accept to respN_valid SHALL be CALC_LAT+2 cycles for a normal op and 1 cycle for div by zero.

Reset
REQ-029 Asserting rst at any time SHALL asynchronously force state=IDLE, last_grant=1, counter=0, result registers=0, and calc enable=0.
REQ-030 While rst is asserted, all outputs SHALL be 0.
REQ-031 An in-flight operation at reset SHALL be discarded and no response issued.
REQ-032 int_calc_16 SHALL be reset with ~rst.

Structure
REQ-033 The shared package calc_defs SHALL hold opcode constants OP_ADD..OP_MOD, FSM state encodings, and the CALC_LAT default.
REQ-034 The block SHALL instantiate exactly one int_calc_16 as its only sub-module, on the same clk.
REQ-035 The arbiter and FSM SHALL be inline; there SHALL be no further sub-modules.

Verification
REQ-036 Single request: req0 add 25,30 -> req0_ready pulses once, resp0_valid after CALC_LAT+2 cycles, sum=55, sign=0, err=0.
REQ-037 Simultaneous requests: req0 sub 20,5 and req1 mul 4,5 valid in the same cycle after reset -> req0 served first (sum=15), then req1 (sum=20); repeating the pair -> req1 served first.
REQ-038 Div by zero: req1 div 10,0 -> calc enable never asserted, resp1_valid 1 cycle after accept, sum=FFFF, err=1.
REQ-039 Backpressure: resp0_ready held low 10 cycles with req1_valid high -> resp0 data stable, req1_ready stays 0, busy=1; release -> IDLE, then req1 granted.
REQ-040 Reset mid-operation: rst low during WAIT of req0 sub 25,30 -> all outputs 0 immediately; after release, no stale resp0_valid and the next req0 add 10,2 returns 12.
